// File: rtl/data_memory_responder.sv
// Word-organised data RAM answering one CPU load/store at a time over
// valid/ready request and response channels, with a fixed access latency.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        requestValid,
    output logic        requestReady,
    input  logic        requestWrite,
    input  logic [31:0] requestAddress,
    input  logic [31:0] requestWriteData,
    input  logic [3:0]  requestByteEnable,
    output logic        responseValid,
    input  logic        responseReady,
    output logic [31:0] responseData,
    output logic        responseError
);

    localparam int             AW     = $clog2(DEPTH_WORDS);
    localparam int             CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]  LOAD   = CW'(LATENCY - 1);
    localparam bit             SINGLE = (LATENCY == 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESPOND} state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_access;
    logic          w_acc_write;
    logic [31:0]   w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic [3:0]    w_acc_be;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rdata;

    assign requestReady = (r_state == S_IDLE);
    assign w_accept     = requestValid && (r_state == S_IDLE);

    // With a single-cycle latency the acceptance edge is also the access edge,
    // so the access works straight from the request port.
    assign w_access    = SINGLE ? w_accept
                                : ((r_state == S_BUSY) && (r_count == CW'(1)));
    assign w_acc_write = SINGLE ? requestWrite      : r_write;
    assign w_acc_addr  = SINGLE ? requestAddress    : r_addr;
    assign w_acc_wdata = SINGLE ? requestWriteData  : r_wdata;
    assign w_acc_be    = SINGLE ? requestByteEnable : r_be;

    // Any address bit above the word index makes the access out of range, so no aliasing.
    assign w_err   = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:AW+2] != '0);
    assign w_idx   = w_acc_addr[AW+1:2];
    assign w_rdata = r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (resetN && w_access && w_acc_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_be          <= '0;
            responseValid <= 1'b0;
            responseData  <= '0;
            responseError <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write <= requestWrite;
                        r_addr  <= requestAddress;
                        r_wdata <= requestWriteData;
                        r_be    <= requestByteEnable;
                        r_count <= LOAD;
                        r_state <= SINGLE ? S_RESPOND : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_count <= r_count - CW'(1);
                    if (w_access) begin
                        r_state <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (responseReady) begin
                        r_state       <= S_IDLE;
                        responseValid <= 1'b0;
                        responseData  <= '0;
                        responseError <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_access) begin
                responseValid <= 1'b1;
                responseError <= w_err;
                responseData  <= (!w_acc_write && !w_err) ? w_rdata : '0;
            end
        end
    end

endmodule
